dmem_access_unit: RTL and testbench

- Sits between the core's memory stage and the synchronous data RAM, on the consuming side of the decoder's memwr/memop (func3) outputs.
- Accepts one load/store request per handshake. Converts it into word address, byte-lane write enables and shifted write data.
- Returns sign- or zero-extended load data with a single-cycle response pulse.
- Detects misaligned or illegal accesses and answers them with an error response, without touching memory.

---
 rtl/dmem_access_unit_pkg.sv | 58 +++++
 rtl/dmem_access_unit_load_align.sv | 31 +++
 rtl/dmem_access_unit.sv | 143 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings and request decode helpers for the data-memory access unit.
package dmem_access_unit_pkg;

  localparam int unsigned OFF_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_RESP
  } state_e;

  // Unsigned ops are load-only; halves and words must be naturally aligned.
  function automatic logic req_illegal(input logic wr, input logic [2:0] op,
                                       input logic [OFF_W-1:0] off);
    logic bad;
    case (op)
      MOP_B:   bad = 1'b0;
      MOP_H:   bad = off[0];
      MOP_W:   bad = (off != 2'b00);
      MOP_BU:  bad = wr;
      MOP_HU:  bad = wr | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_we(input logic [2:0] op, input logic [OFF_W-1:0] off);
    logic [3:0] we;
    case (op)
      MOP_B:   we = 4'(4'b0001 << off);
      MOP_H:   we = off[1] ? 4'b1100 : 4'b0011;
      MOP_W:   we = 4'b1111;
      default: we = 4'b0000;
    endcase
    return we;
  endfunction

  function automatic logic [DATA_W-1:0] rep_wdata(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    case (op)
      MOP_B:   d = {4{wd[7:0]}};
      MOP_H:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_access_unit_load_align.sv
// Load-data lane select and sign/zero extension; purely combinational.
module dmem_load_align
  import dmem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [2:0]        op_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      MOP_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      MOP_BU:  data_o = {24'b0, byte_sel};
      MOP_H:   data_o = {{16{half_sel[15]}}, half_sel};
      MOP_HU:  data_o = {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store front end to a synchronous data RAM: one request at a time,
// optional wait states, lane-shifted writes, extended loads, error responses.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [2:0]              req_op,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_en,
  output logic [3:0]              mem_we,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [2:0]              op_q, op_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic                    mem_en_q, mem_en_d;
  logic [3:0]              mem_we_q, mem_we_d;
  logic [ADDR_W-OFF_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]       load_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_illegal(req_wr, req_op, req_addr[OFF_W-1:0]);
          if (err_d) begin
            state_d = ST_RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ISSUE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state; the *_d request fields
    // already hold the incoming request on the accepting cycle.
    mem_en_d    = (state_d == ST_ISSUE);
    mem_we_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (mem_en_d) begin
      mem_addr_d = addr_d[ADDR_W-1:OFF_W];
      if (wr_d) begin
        mem_we_d    = lane_we(op_d, addr_d[OFF_W-1:0]);
        mem_wdata_d = rep_wdata(op_d, wdata_d);
      end
    end
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = rsp_valid_d & err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_load_align u_load_align (
    .rdata_i (mem_rdata),
    .op_i    (op_q),
    .off_i   (addr_q[OFF_W-1:0]),
    .data_o  (load_data)
  );

  // RAM data arrives in RESP, so load data is steered straight through.
  assign rsp_rdata = (rsp_valid_q && !wr_q && !err_q) ? load_data : '0;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench: a zero-wait and a three-wait instance, each behind a small RAM model.
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  typedef struct packed {logic err; logic [31:0] rdata;} rsp_exp_t;
  typedef struct packed {logic [3:0] we; logic [29:0] addr; logic [31:0] wdata;} mem_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic        mem_en    [2];
  logic [31:0] rsp_rdata [2];
  logic [3:0]  mem_we    [2];
  logic [29:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        req_wr;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] ram [2][16];

  int cyc = 0, n_chk = 0, n_bad = 0;
  int last_rsp [2] = '{0, 0};
  int last_mem [2] = '{0, 0};
  int acc, a1, waited;
  rsp_exp_t rq0[$], rq1[$];
  mem_exp_t mq0[$], mq1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_access_unit #(.WAIT_CYCLES(0), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  dmem_access_unit #(.WAIT_CYCLES(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  // Synchronous RAM: byte-lane writes, read data one cycle after the strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[k][b]) ram[k][mem_addr[k][3:0]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
        mem_rdata[k] <= ram[k][mem_addr[k][3:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rsp_exp_t r;
    mem_exp_t m;
    logic     have;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (rsp_valid[k]) begin
          last_rsp[k] = cyc;
          have = (k == 0) ? (rq0.size() != 0) : (rq1.size() != 0);
          if (!have) chk("rsp_unexp", 32'(rsp_valid[k]), 32'd0);
          else begin
            if (k == 0) r = rq0.pop_front();
            else        r = rq1.pop_front();
            chk("rsp_err", 32'(rsp_err[k]), 32'(r.err));
            chk("rsp_rdata", rsp_rdata[k], r.rdata);
          end
        end else begin
          chk("rsp_err_idle", 32'(rsp_err[k]), 32'd0);
        end
        if (mem_en[k]) begin
          last_mem[k] = cyc;
          have = (k == 0) ? (mq0.size() != 0) : (mq1.size() != 0);
          if (!have) chk("mem_unexp", 32'(mem_en[k]), 32'd0);
          else begin
            if (k == 0) m = mq0.pop_front();
            else        m = mq1.pop_front();
            chk("mem_we", 32'(mem_we[k]), 32'(m.we));
            chk("mem_addr", 32'(mem_addr[k]), 32'(m.addr));
            chk("mem_wdata", mem_wdata[k], m.wdata);
          end
        end else begin
          chk("mem_we_idle", 32'(mem_we[k]), 32'd0);
        end
      end
    end
  end

  task automatic send(input int k, input logic wr, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                      input logic [3:0] e_we, input logic [31:0] e_wd);
    rsp_exp_t r;
    mem_exp_t m;
    r = '{err: e_err, rdata: e_rd};
    m = '{we: e_we, addr: addr[31:2], wdata: e_wd};
    req_wr = wr; req_op = op; req_addr = addr; req_wdata = wd;
    req_valid[k] = 1'b1;
    if (k == 0) begin rq0.push_back(r); if (!e_err) mq0.push_back(m); end
    else        begin rq1.push_back(r); if (!e_err) mq1.push_back(m); end
    waited = 0;
    while (!req_ready[k] && waited < 100) begin @(negedge clk); waited++; end
    if (!req_ready[k]) chk("accept_timeout", 32'(req_ready[k]), 32'd1);
    acc = cyc;
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic st(input int k, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] e_we, input logic [31:0] e_wd);
    send(k, 1'b1, op, addr, wd, 1'b0, 32'd0, e_we, e_wd);
  endtask

  task automatic ld(input int k, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] e_rd);
    send(k, 1'b0, op, addr, 32'h0BAD_F00D, 1'b0, e_rd, 4'h0, 32'd0);
  endtask

  task automatic er(input int k, input logic wr, input logic [2:0] op, input logic [31:0] addr);
    send(k, wr, op, addr, 32'h1234_5678, 1'b1, 32'd0, 4'h0, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq0.size() + rq1.size() + mq0.size() + mq1.size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain_pending", 32'(rq0.size() + rq1.size() + mq0.size() + mq1.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req_wr = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_mem_en", 32'(mem_en[k]), 32'd0);
      chk("rst_mem_we", 32'(mem_we[k]), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rst_ready0", 32'(req_ready[0]), 32'd1);
    chk("rst_ready1", 32'(req_ready[1]), 32'd1);
    @(negedge clk);

    // Zero wait states: stores, extended loads, latency.
    st(0, MOP_W, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    drain();
    chk("st_issue_lat", 32'(last_mem[0] - acc), 32'd1);
    chk("st_rsp_lat", 32'(last_rsp[0] - acc), 32'd2);
    st(0, MOP_B, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    ld(0, MOP_B,  32'h13, 32'hFFFF_FFA5);
    ld(0, MOP_BU, 32'h13, 32'h0000_00A5);
    st(0, MOP_W, 32'h10, 32'h8001_BEEF, 4'b1111, 32'h8001_BEEF);
    ld(0, MOP_H,  32'h12, 32'hFFFF_8001);
    ld(0, MOP_HU, 32'h12, 32'h0000_8001);
    ld(0, MOP_W,  32'h10, 32'h8001_BEEF);
    ld(0, MOP_H,  32'h10, 32'hFFFF_BEEF);
    ld(0, MOP_BU, 32'h10, 32'h0000_00EF);
    a1 = acc;
    ld(0, MOP_B,  32'h11, 32'hFFFF_FFBE);
    chk("legal_thru", 32'(acc - a1), 32'd3);
    st(0, MOP_H, 32'h12, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    ld(0, MOP_W, 32'h10, 32'h1234_BEEF);
    drain();

    // Illegal and misaligned requests never reach the RAM.
    er(0, 1'b0, MOP_W, 32'h02);
    drain();
    chk("err_rsp_lat", 32'(last_rsp[0] - acc), 32'd1);
    er(0, 1'b0, 3'b011, 32'h00);
    a1 = acc;
    er(0, 1'b1, MOP_BU, 32'h20);
    chk("err_thru", 32'(acc - a1), 32'd2);
    er(0, 1'b0, MOP_H, 32'h11);
    er(0, 1'b1, 3'b110, 32'h00);
    er(0, 1'b0, 3'b111, 32'h04);
    er(0, 1'b1, MOP_HU, 32'h08);
    drain();

    // Three wait states: latency and a held second request.
    st(1, MOP_W, 32'h0, 32'h55AA_00FF, 4'b1111, 32'h55AA_00FF);
    drain();
    ld(1, MOP_W, 32'h0, 32'h55AA_00FF);
    drain();
    chk("wait_issue_lat", 32'(last_mem[1] - acc), 32'd4);
    chk("wait_rsp_lat", 32'(last_rsp[1] - acc), 32'd5);
    ld(1, MOP_W, 32'h0, 32'h55AA_00FF);
    a1 = acc;
    ld(1, MOP_BU, 32'h0, 32'h0000_00FF);
    chk("wait_busy_cycles", 32'(waited), 32'd5);
    chk("wait_thru", 32'(acc - a1), 32'd6);
    drain();
    chk("wait_issue_lat2", 32'(last_mem[1] - acc), 32'd4);

    // Reset in the middle of a waiting store discards it entirely.
    st(1, MOP_B, 32'h4, 32'h0000_0099, 4'b0001, 32'h9999_9999);
    @(negedge clk);
    rst = 1'b1;
    rq1.delete();
    mq1.delete();
    #1;
    chk("rst_mid_mem_en", 32'(mem_en[1]), 32'd0);
    chk("rst_mid_mem_we", 32'(mem_we[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(req_ready[1]), 32'd1);
    repeat (8) @(negedge clk);
    st(1, MOP_B, 32'h2, 32'h0000_0077, 4'b0100, 32'h7777_7777);
    ld(1, MOP_W, 32'h0, 32'h5577_00FF);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
